// File: rtl/adc_seq_ctrl_if.sv
// Signal bundle for adc_seq_ctrl: GPIO control/status words, scan tick,
// serial ADC pins and the scan sample stream.
interface adc_seq_ctrl_if;
   logic [9:0] gpio_out_i;
   logic [9:0] gpio_in_o;
   logic       tick_i;
   logic       adc_cs_n;
   logic       adc_sclk;
   logic       adc_din;
   logic       adc_dout;
   logic [9:0] scan_data;
   logic       scan_valid;

   modport master (
      input  gpio_out_i, tick_i, adc_dout,
      output gpio_in_o, adc_cs_n, adc_sclk, adc_din, scan_data, scan_valid
   );
   modport slave (
      output gpio_out_i, tick_i, adc_dout,
      input  gpio_in_o, adc_cs_n, adc_sclk, adc_din, scan_data, scan_valid
   );
endinterface

// File: rtl/adc_seq_ctrl.sv
// Serial 10-bit ADC sequencer arbitrating CPU single-shots against tick-paced scans.
// Optional ADC_SCAN_AVG_EN: scan_data becomes a 4-sample running average.
module adc_seq_ctrl #(
   parameter int         CLK_DIV = 25,
   parameter logic [1:0] SCAN_CH = 2'd0
) (
   input  logic           clk_clk,
   input  logic           reset_reset,
   adc_seq_ctrl_if.master bus
);
   typedef enum logic [1:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD} state_t;

   localparam logic [8:0] PH_LAST   = 9'(CLK_DIV - 1);
   localparam logic [8:0] HOLD_LAST = 9'(2 * CLK_DIV - 1);

   state_t     state;
   logic [8:0] cnt;
   logic [3:0] per;
   logic       hi;
   logic       req_q, ack_q;
   logic       cpu_pend, scan_pend;
   logic [1:0] cpu_ch, cur_ch;
   logic       cur_src;
   logic [9:0] shreg, result_reg;
   logic       done, overrun, last_src;
   logic [1:0] last_ch;
   logic       cs_n_r, sclk_r, din_r, scan_valid_r;
   logic [9:0] gpio_in_r, scan_data_r;

   logic       req, view, scan_en, ack;
   logic [1:0] ch;
   logic       req_rise, ack_rise, cpu_grant, scan_grant, busy;
   logic [15:0] cmd;
   logic [9:0] status;
   logic       unused_gpio;

   assign req         = bus.gpio_out_i[9];
   assign view        = bus.gpio_out_i[8];
   assign scan_en     = bus.gpio_out_i[7];
   assign ack         = bus.gpio_out_i[6];
   assign ch          = bus.gpio_out_i[1:0];
   assign unused_gpio = ^bus.gpio_out_i[5:2];

   assign req_rise   = req & ~req_q;
   assign ack_rise   = ack & ~ack_q;
   assign cpu_grant  = (state == IDLE) && cpu_pend;
   assign scan_grant = (state == IDLE) && !cpu_pend && scan_pend && scan_en;
   assign busy       = (state != IDLE);
   assign cmd        = {2'b11, cur_ch, 12'h000};
   assign status     = {done, busy, last_src, overrun, last_ch, 4'b0000};

`ifdef ADC_SCAN_AVG_EN
   logic [2:0][9:0] hist;
   logic [11:0]     avg_sum;
   assign avg_sum = 12'(shreg) + 12'(hist[0]) + 12'(hist[1]) + 12'(hist[2]);
`endif

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state        <= IDLE;
         cnt          <= '0;
         per          <= '0;
         hi           <= 1'b0;
         req_q        <= 1'b0;
         ack_q        <= 1'b0;
         cpu_pend     <= 1'b0;
         scan_pend    <= 1'b0;
         cpu_ch       <= '0;
         cur_ch       <= '0;
         cur_src      <= 1'b0;
         shreg        <= '0;
         result_reg   <= '0;
         done         <= 1'b0;
         overrun      <= 1'b0;
         last_src     <= 1'b0;
         last_ch      <= '0;
         cs_n_r       <= 1'b1;
         sclk_r       <= 1'b0;
         din_r        <= 1'b0;
         gpio_in_r    <= '0;
         scan_data_r  <= '0;
         scan_valid_r <= 1'b0;
`ifdef ADC_SCAN_AVG_EN
         hist         <= '0;
`endif
      end else begin
         req_q        <= req;
         ack_q        <= ack;
         scan_valid_r <= 1'b0;
         gpio_in_r    <= view ? result_reg : status;

         if (req_rise && !cpu_pend) begin
            cpu_pend <= 1'b1;
            cpu_ch   <= ch;
         end else if (cpu_grant) begin
            cpu_pend <= 1'b0;
         end

         // a tick landing in the grant cycle re-arms the request, not an overrun
         if (!scan_en) scan_pend <= 1'b0;
         else if (bus.tick_i) begin
            scan_pend <= 1'b1;
            if (scan_pend && !scan_grant) overrun <= 1'b1;
         end else if (scan_grant) scan_pend <= 1'b0;

         if (ack_rise) begin
            done    <= 1'b0;
            overrun <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (cpu_grant || scan_grant) begin
                  state   <= CS_SETUP;
                  cnt     <= '0;
                  cs_n_r  <= 1'b0;
                  cur_src <= !cpu_grant;
                  cur_ch  <= cpu_grant ? cpu_ch : SCAN_CH;
               end
            end
            CS_SETUP: begin
               if (cnt == PH_LAST) begin
                  state <= SHIFT;
                  cnt   <= '0;
                  per   <= '0;
                  hi    <= 1'b0;
                  din_r <= cmd[15];
               end else cnt <= cnt + 9'd1;
            end
            SHIFT: begin
               if (cnt != PH_LAST) cnt <= cnt + 9'd1;
               else begin
                  cnt <= '0;
                  if (!hi) begin
                     hi     <= 1'b1;
                     sclk_r <= 1'b1;
                     if (per >= 4'd5 && per <= 4'd14) shreg <= {shreg[8:0], bus.adc_dout};
                  end else begin
                     hi     <= 1'b0;
                     sclk_r <= 1'b0;
                     if (per == 4'd15) begin
                        state  <= CS_HOLD;
                        cs_n_r <= 1'b1;
                        din_r  <= 1'b0;
                     end else begin
                        per   <= per + 4'd1;
                        din_r <= cmd[4'd14 - per];
                     end
                  end
               end
            end
            CS_HOLD: begin
               if (cnt != HOLD_LAST) cnt <= cnt + 9'd1;
               else begin
                  state <= IDLE;
                  cnt   <= '0;
                  if (!cur_src) begin
                     result_reg <= shreg;
                     done       <= 1'b1;
                     last_src   <= 1'b0;
                     last_ch    <= cur_ch;
                  end else begin
                     scan_valid_r <= 1'b1;
                     last_src     <= 1'b1;
`ifdef ADC_SCAN_AVG_EN
                     scan_data_r  <= avg_sum[11:2];
                     hist         <= {hist[1], hist[0], shreg};
`else
                     scan_data_r  <= shreg;
`endif
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.adc_cs_n   = cs_n_r;
   assign bus.adc_sclk   = sclk_r;
   assign bus.adc_din    = din_r;
   assign bus.gpio_in_o  = gpio_in_r;
   assign bus.scan_data  = scan_data_r;
   assign bus.scan_valid = scan_valid_r;
endmodule

// File: tb/tb_adc_seq_ctrl.sv
// Bench for adc_seq_ctrl: serial ADC model, CPU vector table, randomized
// conversions/scans and hand-written collision, overrun, reset and ack-race cases.
module tb_adc_seq_ctrl;
   localparam int         CLK_DIV = 25;
   localparam logic [1:0] SCAN_CH = 2'd0;

   logic clk, rst;
   adc_seq_ctrl_if bus();

   adc_seq_ctrl #(.CLK_DIV(CLK_DIV), .SCAN_CH(SCAN_CH)) dut (
      .clk_clk(clk), .reset_reset(rst), .bus(bus.master)
   );

   typedef struct {
      logic [1:0] ch;
      logic [9:0] val;
      logic [9:0] exp_res;
      logic [9:0] exp_stat;
   } vec_t;

   int         pass_cnt = 0;
   int         chk_cnt  = 0;
   int         sv_cnt   = 0;
   logic       r_req = 0, r_view = 0, r_scan = 0, r_ack = 0;
   logic [1:0] r_ch = '0;
   logic [9:0] val_tbl [4];
   logic [3:0] cmd_q [$];
   int         hq [$];
   int         m_per = 0, m_gap = 0, gap_last = 0;
   logic       m_cs_q = 1'b1, m_sclk_q = 1'b0;
   logic [3:0] m_cmd = '0;
   logic [1:0] m_ch = '0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ADC model: latches the 4 command bits on sclk rises, shifts the channel value
   // out MSB first on sclk falls so it is stable for periods 6..15.
   initial begin
      bus.adc_dout = 1'b0;
      forever begin
         @(negedge clk);
         if (m_cs_q && !bus.adc_cs_n) begin
            m_per = 0; m_cmd = '0; gap_last = m_gap; bus.adc_dout = 1'b0;
         end
         if (!bus.adc_cs_n) begin
            if (!m_sclk_q && bus.adc_sclk) begin
               m_per++;
               if (m_per <= 4) m_cmd = {m_cmd[2:0], bus.adc_din};
               if (m_per == 4) begin m_ch = m_cmd[1:0]; cmd_q.push_back(m_cmd); end
            end else if (m_sclk_q && !bus.adc_sclk) begin
               if (m_per >= 5 && m_per <= 14) bus.adc_dout = val_tbl[m_ch][14 - m_per];
               else bus.adc_dout = 1'b0;
            end
         end
         m_gap    = bus.adc_cs_n ? m_gap + 1 : 0;
         m_cs_q   = bus.adc_cs_n;
         m_sclk_q = bus.adc_sclk;
      end
   end

   initial forever begin
      @(negedge clk);
      if (bus.scan_valid) sv_cnt++;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive();
      bus.gpio_out_i = {r_req, r_view, r_scan, r_ack, 4'b0000, r_ch};
   endtask

   task automatic pulse_tick();
      bus.tick_i = 1'b1;
      step(1);
      bus.tick_i = 1'b0;
   endtask

   task automatic ack_pulse();
      r_req = 1'b0; r_ack = 1'b1; drive(); step(1);
      r_ack = 1'b0; drive(); step(2);
   endtask

   task automatic wait_status(input int b, input string nm);
      bit ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (bus.gpio_in_o[b]) begin ok = 1'b1; break; end
         step(1);
      end
      check({nm, " wait"}, 32'(ok), 32'd1);
   endtask

   task automatic wait_scan(input int n0, input string nm);
      bit ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (sv_cnt > n0) begin ok = 1'b1; break; end
         step(1);
      end
      check({nm, " scan wait"}, 32'(ok), 32'd1);
   endtask

   task automatic do_reset();
      rst = 1'b1; step(3); rst = 1'b0;
      hq.delete();
      repeat (3) hq.push_back(0);
      step(1);
   endtask

   function automatic logic [9:0] scan_model(input logic [9:0] v);
`ifdef ADC_SCAN_AVG_EN
      int s = int'(v) + hq[0] + hq[1] + hq[2];
      hq.push_front(int'(v));
      void'(hq.pop_back());
      return 10'(s / 4);
`else
      return v;
`endif
   endfunction

   task automatic cpu_conv(input logic [1:0] c, input logic [9:0] exp_res,
                           input logic [9:0] exp_stat, input string nm);
      r_ch = c; r_req = 1'b1; drive();
      wait_status(9, nm);
      check({nm, " status"}, 32'(bus.gpio_in_o), 32'(exp_stat));
      r_view = 1'b1; drive(); step(2);
      check({nm, " result"}, 32'(bus.gpio_in_o), 32'(exp_res));
      r_view = 1'b0; drive();
      ack_pulse();
   endtask

   initial begin
      vec_t       vecs [4];
      logic [9:0] v, exp_sd;
      logic [1:0] c;
      int         n0;
      bit         ok;

      vecs[0] = '{ch: 2'd0, val: 10'h000, exp_res: 10'h000, exp_stat: 10'h200};
      vecs[1] = '{ch: 2'd1, val: 10'h3FF, exp_res: 10'h3FF, exp_stat: 10'h210};
      vecs[2] = '{ch: 2'd2, val: 10'h155, exp_res: 10'h155, exp_stat: 10'h220};
      vecs[3] = '{ch: 2'd3, val: 10'h201, exp_res: 10'h201, exp_stat: 10'h230};
      foreach (val_tbl[i]) val_tbl[i] = '0;
      bus.tick_i = 1'b0;
      drive();

      // reset state
      do_reset();
      check("reset pins", {bus.adc_cs_n, bus.adc_sclk, bus.adc_din}, 3'b100);
      check("reset gpio_in", bus.gpio_in_o, 10'h000);
      check("reset scan", {bus.scan_valid, bus.scan_data}, 11'h000);

      // CPU conversion with exact latency
      val_tbl[2] = 10'h2A5;
      cmd_q.delete();
      r_ch = 2'd2; r_req = 1'b1; drive();
      step(2);
      check("cs_n falls", bus.adc_cs_n, 1'b0);
      step(875);
      check("done before 877", bus.gpio_in_o[9], 1'b0);
      step(1);
      check("done at 877", bus.gpio_in_o[9], 1'b1);
      check("cmd bits", (cmd_q.size() > 0) ? cmd_q[0] : 4'h0, 4'b1110);
      check("status ch2", bus.gpio_in_o, 10'h220);
      r_view = 1'b1; drive(); step(2);
      check("result 2A5", bus.gpio_in_o, 10'h2A5);
      r_view = 1'b0; drive();
      ack_pulse();
      check("ack clears done", bus.gpio_in_o, 10'h020);

      // vector table
      for (int i = 0; i < 4; i++) begin
         val_tbl[vecs[i].ch] = vecs[i].val;
         cpu_conv(vecs[i].ch, vecs[i].exp_res, vecs[i].exp_stat, $sformatf("vec%0d", i));
      end

      // randomized CPU conversions
      for (int i = 0; i < 5; i++) begin
         c = 2'($urandom_range(3));
         v = 10'($urandom);
         val_tbl[c] = v;
         cpu_conv(c, v, {4'b1000, c, 4'b0000}, $sformatf("rand%0d", i));
      end

      // collision: req edge and tick together
      val_tbl[1] = 10'h1C3;
      val_tbl[SCAN_CH] = 10'h0F7;
      cmd_q.delete();
      n0 = sv_cnt;
      r_ch = 2'd1; r_req = 1'b1; r_scan = 1'b1; drive();
      pulse_tick();
      wait_scan(n0, "collision");
      step(3);
      exp_sd = scan_model(10'h0F7);
      check("coll order n", cmd_q.size(), 2);
      check("coll first cpu", (cmd_q.size() > 0) ? cmd_q[0] : 4'h0, 4'b1101);
      check("coll second scan", (cmd_q.size() > 1) ? cmd_q[1] : 4'h0, {2'b11, SCAN_CH});
      check("coll idle gap", gap_last, 2 * CLK_DIV + 1);
      check("coll one pulse", sv_cnt, n0 + 1);
      check("coll scan_data", bus.scan_data, exp_sd);
      check("coll status", bus.gpio_in_o, 10'h290);
      r_view = 1'b1; drive(); step(2);
      check("coll cpu result", bus.gpio_in_o, 10'h1C3);
      r_view = 1'b0; drive();
      ack_pulse();

      // overrun: two ticks during a CPU frame
      val_tbl[3] = 10'h0AA;
      val_tbl[SCAN_CH] = 10'h321;
      n0 = sv_cnt;
      r_ch = 2'd3; r_req = 1'b1; drive();
      step(20); pulse_tick();
      step(9);  pulse_tick();
      step(2);
      check("overrun set", bus.gpio_in_o[6], 1'b1);
      wait_scan(n0, "overrun");
      step(2);
      exp_sd = scan_model(10'h321);
      check("overrun status", bus.gpio_in_o, 10'h2F0);
      check("overrun scan_data", bus.scan_data, exp_sd);
      r_scan = 1'b0; drive();
      ack_pulse();
      check("ack clears 9,6", bus.gpio_in_o, 10'h0B0);

      // ack edge in the exact completion cycle
      val_tbl[0] = 10'h111;
      r_ch = 2'd0; r_req = 1'b1; drive();
      step(876);
      r_ack = 1'b1; drive();
      step(2);
      check("race done kept", bus.gpio_in_o[9], 1'b1);
      r_ack = 1'b0; r_req = 1'b0; drive(); step(1);
      r_ack = 1'b1; drive(); step(2);
      check("race later ack", bus.gpio_in_o[9], 1'b0);
      r_ack = 1'b0; drive(); step(1);

      // reset in SHIFT period 8
      val_tbl[2] = 10'h3C3;
      r_ch = 2'd2; r_req = 1'b1; drive();
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         if (!bus.adc_cs_n && m_per == 8) begin ok = 1'b1; break; end
         step(1);
      end
      check("reach period 8", 32'(ok), 32'd1);
      rst = 1'b1; step(1);
      check("mid reset pins", {bus.adc_cs_n, bus.adc_sclk}, 2'b10);
      check("mid reset status", bus.gpio_in_o, 10'h000);
      rst = 1'b0; r_req = 1'b0; drive();
      hq.delete();
      repeat (3) hq.push_back(0);
      step(40);
      check("no stale done", bus.gpio_in_o, 10'h000);
      val_tbl[1] = 10'h2D2;
      cpu_conv(2'd1, 10'h2D2, 10'h210, "after reset");

      // scan stream: fixed samples then random ones
      do_reset();
      r_scan = 1'b1; drive();
      for (int i = 0; i < 8; i++) begin
         v = (i < 4) ? 10'(100 * (i + 1)) : 10'($urandom);
         val_tbl[SCAN_CH] = v;
         exp_sd = scan_model(v);
         n0 = sv_cnt;
         pulse_tick();
         wait_scan(n0, $sformatf("scan%0d", i));
         step(2);
         check($sformatf("scan%0d data", i), bus.scan_data, exp_sd);
         check($sformatf("scan%0d pulses", i), sv_cnt, n0 + 1);
      end
      r_scan = 1'b0; drive(); step(2);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule

// File: doc/adc_seq_ctrl.md
# adc_seq_ctrl

Sequencer and arbiter for the board's serial 10-bit ADC.
- Shares the ADC between two requesters: CPU single-shot conversions, driven through the 10-bit ADC GPIO pair, and hardware background scans paced by the 5 kHz tick.
- Generates the full serial frame (cs_n, sclk, din) and captures dout.
- Presents status or CPU result words on the GPIO input port.
- Streams scan samples to the thermostat logic.

## Interface
- CLK_DIV, 25: clk_clk cycles per sclk half-period; legal range 2..255.
- SCAN_CH, 0: 2-bit ADC channel used by background scans.
- clk_clk  in  1  system clock; the only clock.
- reset_reset  in  1  synchronous, active-high reset.
- gpio_out_i  in  10  CPU control word, driven from the GPIO out_port.
  - [9] req
  - [8] view select
  - [7] scan_en
  - [6] ack
  - [1:0] channel
  - others reserved and ignored
- gpio_in_o  out  10  word to the GPIO in_port; status view or CPU result.
- tick_i  in  1  single-cycle scan pulse, already synchronous to clk_clk.
- adc_cs_n  out  1  ADC chip select, active low.
- adc_sclk  out  1  ADC serial clock.
- adc_din  out  1  command bits to the ADC.
- adc_dout  in  1  conversion bits from the ADC.
- scan_data  out  10  latest scan result.
- scan_valid  out  1  one-cycle pulse when scan_data updates.

## Operation
- Edge detect: req and ack are registered every cycle. A rising edge is registered value 0 with current input 1.
- CPU request
  - A req rising edge sets cpu_pend and captures the channel.
  - A second edge while cpu_pend is set is ignored.
  - A req edge while busy with cpu_pend clear is accepted and queued.
- Scan request
  - tick_i with scan_en=1 sets scan_pend.
  - tick_i while scan_pend is already set sets sticky overrun.
- Arbitration happens in IDLE only:
  - cpu_pend has priority over scan_pend.
  - A running frame is never preempted.
  - If a CPU edge and a tick arrive in the same cycle, the CPU frame runs first; the scan starts the cycle after the CPU frame returns to IDLE.
- FSM states: IDLE → CS_SETUP → SHIFT → CS_HOLD → IDLE.
  - CS_SETUP: cs_n=0, sclk=0, lasts CLK_DIV cycles.
  - SHIFT: 16 sclk periods. Each period is sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - CS_HOLD: cs_n=1, sclk=0, lasts 2·CLK_DIV cycles.
- Frame format
  - din changes on the first cycle of each low phase, MSB first: start=1, single-ended=1, ch[1], ch[0], then 0 for periods 5–16.
  - dout is sampled in the cycle sclk rises, during periods 6–15, MSB first, into a 10-bit shift register.
  - Period 16 is ignored.
- Frame completion (on the CS_HOLD→IDLE transition)
  - CPU frame: result_reg is loaded, done=1, last_src=0, last_ch is updated.
  - Scan frame: scan_data is loaded, scan_valid pulses, last_src=1.
- Ack: an ack rising edge clears done and overrun. If done is being set in the same cycle, set wins; overrun is still cleared.
- gpio_in_o
  - view=0: {done, busy, last_src, overrun, last_ch[1:0], 4'b0000}.
  - view=1: result_reg.
  - Registered output; it reflects a view change one cycle later.
- Clearing scan_en drops a pending scan request; a scan frame already running completes.

## Timing
- Reset values: adc_cs_n=1, adc_sclk=0, adc_din=0, gpio_in_o=0, scan_data=0, scan_valid=0.
- Reset clears all flags, both pending bits and result_reg.
- Reset mid-frame forces IDLE on the next edge with cs_n=1; the partial result is discarded.
- Frame length: 35·CLK_DIV cycles from leaving IDLE to returning to IDLE.
- CPU latency with the ADC idle: done is visible in the status view 35·CLK_DIV+2 cycles after the first cycle req is sampled high. That is 877 cycles at CLK_DIV=25.
- Minimum gap between frames: one IDLE cycle.
- busy=1 from leaving IDLE through CS_HOLD.

## Configuration
- ADC_SCAN_AVG_EN defined
  - scan_data is the average of the last four scan samples: a 12-bit sum of a 4-entry history, shifted right by 2.
  - The history resets to 0, so the first three outputs include zeros.
  - scan_valid timing is unchanged.
- ADC_SCAN_AVG_EN undefined: scan_data is the raw latest sample, and no history registers are synthesized.

## Test plan
- CPU conversion: reset; ADC model returns 10'h2A5 on ch 2; drive gpio_out_i=10'h202, then set view=1 → cs_n falls, din bits 1,1,1,0; done=1 at cycle 877; gpio_in_o=10'h2A5.
- Collision: CPU req edge and tick_i in the same cycle with scan_en=1 → CPU frame on ch 1 first; scan frame on SCAN_CH starts one idle cycle later; scan_valid pulses once with the model value.
- Overrun: scan_en=1; two ticks 10 cycles apart while a CPU frame runs → status bit 6=1. An ack edge clears bits 9 and 6.
- Reset mid-SHIFT: assert reset at sclk period 8 → next edge cs_n=1, sclk=0, status=0; a new req afterwards completes normally.
- Ack/done race: ack edge in the exact cycle a CPU frame completes → done stays 1.
- With ADC_SCAN_AVG_EN: scan samples 100, 200, 300, 400 → scan_data 25, 75, 150, 250.
